// File: rtl/instr_fetch_queue_pkg.sv
// Shared constants, entry type and helper function for the instruction-fetch queue.
// Optional zero-latency bypass is enabled by defining IFQ_BYPASS_EN.
package if_pkg;

    localparam int          PC_INCR    = 4;
    localparam logic [31:0] NOP        = 32'h0000_0000;
    localparam int          IF_NB_DATA = 32;
    localparam int          IF_NB_PC   = 32;

    // Entry shape at the default widths; the top builds the same layout at its own widths.
    typedef struct packed {
        logic [IF_NB_DATA-1:0] instruction;
        logic [IF_NB_PC-1:0]   pc;
    } ifq_entry_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Load, redirect/halt control and decode handshake between the fetch stage and its neighbours.
// The fetch stage uses the slave modport; the controller/decode side uses master.
interface instr_fetch_queue_if #(
    parameter int NB_DATA     = 32,
    parameter int NB_ADDR     = 8,
    parameter int NB_PC       = 32,
    parameter int QUEUE_DEPTH = 4
) ();
    import if_pkg::*;

    localparam int CNT_W = clog2(QUEUE_DEPTH + 1);

    logic               i_load_we;
    logic [NB_ADDR-1:0] i_load_addr;
    logic [NB_DATA-1:0] i_load_data;
    logic               i_redirect;
    logic [NB_PC-1:0]   i_redirect_pc;
    logic               i_halt;

    // Handshake: an entry transfers at a rising edge where o_valid && i_ready;
    // o_valid never depends on i_ready, and the head holds until accepted or flushed.
    logic               i_ready;
    logic               o_valid;
    logic [NB_DATA-1:0] o_instruction;
    logic [NB_PC-1:0]   o_pc;
    logic [NB_PC-1:0]   o_pc4;
    logic               o_full;

    logic [NB_PC-1:0]   dbg_pc;
    logic [CNT_W-1:0]   dbg_count;

    modport master (
        output i_load_we, i_load_addr, i_load_data,
        output i_redirect, i_redirect_pc, i_halt, i_ready,
        input  o_valid, o_instruction, o_pc, o_pc4, o_full,
        input  dbg_pc, dbg_count
    );

    modport slave (
        input  i_load_we, i_load_addr, i_load_data,
        input  i_redirect, i_redirect_pc, i_halt, i_ready,
        output o_valid, o_instruction, o_pc, o_pc4, o_full,
        output dbg_pc, dbg_count
    );

endinterface

// File: rtl/instr_fetch_queue_fifo.sv
// Flushable synchronous FIFO holding prefetched {instruction, pc} entries.
// Push into a full FIFO is accepted only together with a pop; flush overrides both.
module ifq_fifo
    import if_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int PTR_W = clog2(DEPTH),
    localparam int CNT_W = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [WIDTH-1:0] store_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is read out until count says it is valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            store_q[wr_ptr_q] <= din_i;
        end
    end

    assign head_o  = store_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// MIPS fetch stage: loadable instruction memory, byte PC, prefetch queue to decode.
// Define IFQ_BYPASS_EN to present a fetched word in the same cycle when the queue is empty.
module instr_fetch_queue
    import if_pkg::*;
#(
    parameter int          NB_DATA     = 32,
    parameter int          NB_ADDR     = 8,
    parameter int          NB_PC       = 32,
    parameter int          QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                i_rst,
    instr_fetch_queue_if.slave  bus
);

    localparam int CNT_W   = clog2(QUEUE_DEPTH + 1);
    localparam int ENTRY_W = NB_DATA + NB_PC;

    typedef struct packed {
        logic [NB_DATA-1:0] instruction;
        logic [NB_PC-1:0]   pc;
    } entry_t;

    logic [NB_DATA-1:0] mem_q [2**NB_ADDR];
    logic [NB_PC-1:0]   pc_q, pc_d;
    logic [NB_ADDR-1:0] fetch_idx;
    entry_t             fetch_entry;
    entry_t             fifo_head;
    entry_t             head;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_empty;
    logic               fifo_full;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fetch;
    logic               head_valid;
    logic               unused_redirect_lsbs;

    always_ff @(posedge clk) begin
        if (bus.i_load_we) begin
            mem_q[bus.i_load_addr] <= bus.i_load_data;
        end
    end

    // Word index truncates the byte PC, so the memory wraps every 2^NB_ADDR words.
    assign fetch_idx               = pc_q[NB_ADDR+1:2];
    assign fetch_entry.instruction = mem_q[fetch_idx];
    assign fetch_entry.pc          = pc_q;

    assign fifo_pop = !fifo_empty && bus.i_ready;
    assign fetch    = !bus.i_load_we && !bus.i_halt && !bus.i_redirect
                      && (!fifo_full || fifo_pop);

`ifdef IFQ_BYPASS_EN
    logic bypass;
    assign bypass     = fetch && fifo_empty;
    assign head_valid = !fifo_empty || bypass;
    assign head       = fifo_empty ? fetch_entry : fifo_head;
    assign fifo_push  = fetch && !(bypass && bus.i_ready);
`else
    assign head_valid = !fifo_empty;
    assign head       = fifo_head;
    assign fifo_push  = fetch;
`endif

    ifq_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (i_rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (bus.i_redirect),
        .din_i   (fetch_entry),
        .head_o  (fifo_head),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // Redirect outranks everything; the target is forced to a word boundary.
    always_comb begin
        pc_d = pc_q;
        if (bus.i_redirect) begin
            pc_d = {bus.i_redirect_pc[NB_PC-1:2], 2'b00};
        end else if (fetch) begin
            pc_d = pc_q + NB_PC'(PC_INCR);
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            pc_q <= NB_PC'(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign unused_redirect_lsbs = ^bus.i_redirect_pc[1:0];

    assign bus.o_valid       = head_valid;
    assign bus.o_instruction = head_valid ? head.instruction : NB_DATA'(NOP);
    assign bus.o_pc          = head_valid ? head.pc : '0;
    assign bus.o_pc4         = head_valid ? head.pc + NB_PC'(PC_INCR) : '0;
    assign bus.o_full        = fifo_full;
    assign bus.dbg_pc        = pc_q;
    assign bus.dbg_count     = fifo_count;

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
Parametrised instruction-fetch stage for the MIPS pipeline.
- Holds a word-addressed instruction memory with a load port.
- Keeps a byte-addressed PC and prefetches into a small flushable queue.
- Presents {instruction, PC, PC+4} to decode over a valid/ready handshake.
- Adds redirect-with-flush and decode back-pressure on top of plain halt/stall fetch.

Parameters:
NB_DATA, 32, instruction width.
NB_ADDR, 8, instruction-memory word-address bits (depth 2^NB_ADDR words).
NB_PC, 32, PC width (byte address).
QUEUE_DEPTH, 4, prefetch entries; power of 2, >= 2.
RESET_PC, 0, PC value after reset; word aligned.

Ports:
clk  in  1  clock, rising edge.
i_rst  in  1  asynchronous, active-high reset.
i_load_we  in  1  memory write enable; fetch suspended while high.
i_load_addr  in  NB_ADDR  word address for load.
i_load_data  in  NB_DATA  load data.
i_redirect  in  1  jump/branch taken; flush and restart.
i_redirect_pc  in  NB_PC  target byte address; bits [1:0] ignored.
i_halt  in  1  stop fetching; queue may drain.
i_ready  in  1  decode accepts head entry.
o_valid  out  1  head entry valid.
o_instruction  out  NB_DATA  head instruction; 0 when !o_valid.
o_pc  out  NB_PC  PC of head instruction.
o_pc4  out  NB_PC  o_pc + 4.
o_full  out  1  queue holds QUEUE_DEPTH entries.

Behaviour:
- Reset (async, immediate):
  - pc = RESET_PC; queue empty (count 0, pointers 0).
  - o_valid = 0, o_instruction = 0, o_pc = 0, o_pc4 = 0, o_full = 0.
  - Memory array is NOT cleared.
- Memory:
  - Synchronous write on the clk edge when i_load_we.
  - Asynchronous read at word index pc[NB_ADDR+1:2].
- pop = o_valid && i_ready.
- fetch = !i_load_we && !i_halt && !i_redirect && (count < QUEUE_DEPTH || pop).
  - On fetch: enqueue {mem[idx], pc}; pc <= pc + 4, modulo 2^NB_PC.
  - Memory index wraps naturally by truncation, e.g. with NB_ADDR=8, pc 0x400 reads mem[0].
- Simultaneous push and pop:
  - Legal at any count, including full; count unchanged.
  - Push into empty queue with pop=0: entry visible the next cycle (1-cycle fetch latency).
- Redirect (highest priority):
  - At the edge where i_redirect=1: queue flushed, pc <= {i_redirect_pc[NB_PC-1:2], 2'b00}.
  - No enqueue that edge. A pop in the same cycle is still considered accepted by decode, but the entry is discarded with the flush.
  - o_valid = 0 for the following cycle.
  - First target instruction valid after the next edge.
- Halt: no fetch, pc holds, pops continue; deassert resumes at held pc.
- Load while halted or running: fetch suspended; queue contents untouched.
  - Software must redirect after loading to discard stale prefetches.
- Ordering: entries leave in strict fetch order; none lost or duplicated under any i_ready pattern.
- o_full = (count == QUEUE_DEPTH).
- Outputs are driven combinationally from the queue head register.

Optional Feature:
IFQ_BYPASS_EN
- Defined: when the queue is empty and fetch=1, the fetched word is presented combinationally in the same cycle (o_valid=1, o_pc=pc).
  - If i_ready=1, it is consumed without being enqueued; otherwise it is enqueued normally.
  - Zero-cycle fetch latency.
- Undefined: no bypass; minimum one-cycle latency as above.

Decomposition:
- Package if_pkg:
  - PC_INCR = 4.
  - NOP encoding 32'h0000_0000.
  - Queue-entry typedef {instruction, pc}.
  - Function clog2 for pointer widths.
- One sub-module: ifq_fifo
  - Parametrised flushable synchronous FIFO: push/pop/flush, count, head output.
  - Instantiated once; memory array and PC logic stay in the top.

Test Plan:
1. Load mem[0..3] = 0x11,0x22,0x33,0x44; then i_ready=1 → o_instruction 0x11..0x44 on consecutive cycles; o_pc 0,4,8,12; o_pc4 4,8,12,16.
2. i_ready=0 for 10 cycles, QUEUE_DEPTH=4 → o_full after 4 fetch edges, pc holds 0x10; then i_ready=1 → 0x11..0x44 in order, no gaps or duplicates.
3. Queue holding 3 entries, redirect to 0x20 → old entries never presented; next valid o_pc=0x20 with o_instruction=mem[8], two edges after redirect.
4. Full queue with i_ready=1 and i_redirect=1 in the same cycle → flush wins; count 0 next cycle; pc=target.
5. i_halt high for 5 cycles → queue drains to empty, pc unchanged, o_valid=0; release → fetch resumes at held pc.
6. Assert i_rst mid-stream between edges → o_valid, o_pc, o_instruction go 0 immediately; after release o_pc=RESET_PC with mem contents intact. Also cover pc 0x3FC → 0x400 fetching mem[0].
